// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: a CPU port and a debug/loader port share one single-port
// synchronous RAM. Each access takes an ISSUE cycle (IDLE) and a completion cycle (XFER).
module mem_arbiter #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_write,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_read,
  output logic          ram_write,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;   // 0 = CPU, 1 = debug
  logic       write_q, write_d;
  logic [3:0] run_cnt_q, run_cnt_d;

  logic cpu_valid;
  logic cpu_is_write;
  logic any_req;
  logic dbg_win;

  always_comb begin
    cpu_valid    = (cpu_cmd == 2'b01) || (cpu_cmd == 2'b10);
    cpu_is_write = (cpu_cmd == 2'b10);
    any_req      = cpu_valid || dbg_req;
    // CPU has priority unless debug has waited BURST CPU grants.
    dbg_win      = dbg_req && (!cpu_valid || (run_cnt_q == BURST_C));

    state_d   = state_q;
    owner_d   = owner_q;
    write_d   = write_q;
    run_cnt_d = run_cnt_q;
    ram_addr  = '0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_wdata = '0;
    cpu_done  = 1'b0;
    dbg_done  = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = XFER;
          owner_d = dbg_win;
          if (dbg_win) begin
            write_d   = dbg_write;
            ram_addr  = dbg_addr;
            ram_write = dbg_write;
            ram_read  = !dbg_write;
            ram_wdata = dbg_write ? dbg_wdata : '0;
          end else begin
            write_d   = cpu_is_write;
            ram_addr  = cpu_addr;
            ram_write = cpu_is_write;
            ram_read  = !cpu_is_write;
            ram_wdata = cpu_is_write ? cpu_wdata : '0;
          end
        end
      end
      XFER: begin
        state_d = IDLE;
        if (owner_q) begin
          dbg_done = 1'b1;
          if (!write_q) dbg_rdata = ram_rdata;
        end else begin
          cpu_done = 1'b1;
          if (!write_q) cpu_rdata = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!dbg_req) begin
      run_cnt_d = 4'd0;
    end else if ((state_q == IDLE) && any_req) begin
      run_cnt_d = dbg_win ? 4'd0 : (run_cnt_q + 4'd1);
    end

    // Reset aborts an in-flight access: no strobes, no done pulse, no read data.
    if (reset) begin
      ram_read  = 1'b0;
      ram_write = 1'b0;
      cpu_done  = 1'b0;
      dbg_done  = 1'b0;
      cpu_rdata = '0;
      dbg_rdata = '0;
    end

    cpu_stall = cpu_valid && !cpu_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      write_q   <= 1'b0;
      run_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      write_q   <= write_d;
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, shadow memory model and a read-data
// expected queue; inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_done, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_write;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_read, ram_write;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] model   [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks (call 1 unit after posedge) ----------------
  task automatic do_op(input logic is_dbg, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic          seen;
    logic [DW-1:0] exp;
    int            lat;
    seen = 1'b0;
    lat  = 0;
    if (wr) model[a] = d;
    else    exp_q.push_back(model[a]);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_write = wr; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_cmd = wr ? 2'b10 : 2'b01; cpu_addr = a; cpu_wdata = d;
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (is_dbg ? dbg_done : cpu_done) begin
        seen = 1'b1;
        lat  = i;
        check("op_other_done", is_dbg ? cpu_done : dbg_done, 0);
        check("op_other_rdata", is_dbg ? cpu_rdata : dbg_rdata, 0);
        if (!is_dbg) check("op_stall_at_done", cpu_stall, 0);
        if (!wr) begin
          exp = exp_q.pop_front();
          check(is_dbg ? "op_dbg_rdata" : "op_cpu_rdata",
                is_dbg ? dbg_rdata : cpu_rdata, exp);
        end
      end else if (!is_dbg) begin
        check("op_stall_pending", cpu_stall, 1);
      end
    end
    if (!seen) begin
      check("op_done_timeout", 0, 1);
      if (!wr && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("op_latency", lat, 1);
    end
    @(posedge clk); #1;
    cpu_cmd = 2'b00;
    dbg_req = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0]    pat;
    int            k, strobes, dones;
    logic [DW-1:0] exp;

    for (int i = 0; i < (1<<AW); i++) model[i] = '0;
    for (int i = 0; i < (1<<AW); i++) ram_mem[i] = '0;
    reset = 1'b1;
    cpu_cmd = 2'b01; cpu_addr = 9'h003; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 9'h004; dbg_wdata = 16'h5555;

    // Reset: requests present, yet no strobes or completions.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_dbg_done", dbg_done, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_cpu_stall", cpu_stall, 1);
    step();
    reset = 1'b0; cpu_cmd = 2'b00; dbg_req = 1'b0;
    @(negedge clk);
    check("post_rst_ram_read", ram_read, 0);
    check("post_rst_ram_write", ram_write, 0);
    check("post_rst_cpu_stall", cpu_stall, 0);
    step();

    // CPU write 0x005 <= 0xABCD, step by step.
    cpu_cmd = 2'b10; cpu_addr = 9'h005; cpu_wdata = 16'hABCD; model[9'h005] = 16'hABCD;
    @(negedge clk);
    check("wr_ram_write", ram_write, 1);
    check("wr_ram_read", ram_read, 0);
    check("wr_ram_addr", ram_addr, 9'h005);
    check("wr_ram_wdata", ram_wdata, 16'hABCD);
    check("wr_stall_issue", cpu_stall, 1);
    check("wr_done_issue", cpu_done, 0);
    @(negedge clk);
    check("wr_done_xfer", cpu_done, 1);
    check("wr_strobe_xfer", ram_write, 0);
    check("wr_stall_xfer", cpu_stall, 0);
    step();
    cpu_cmd = 2'b00;
    do_op(1'b0, 1'b0, 9'h005, '0);

    // Debug preload then debug read.
    do_op(1'b1, 1'b1, 9'h010, 16'h1234);
    do_op(1'b1, 1'b0, 9'h010, '0);

    // Simultaneous CPU read and debug read, run_cnt = 0: CPU first, then debug.
    cpu_cmd = 2'b01; cpu_addr = 9'h005; exp_q.push_back(model[9'h005]);
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 9'h010; exp_q.push_back(model[9'h010]);
    @(negedge clk);
    check("sim_t_read", ram_read, 1);
    check("sim_t_addr", ram_addr, 9'h005);
    @(negedge clk);
    check("sim_t1_cpu_done", cpu_done, 1);
    check("sim_t1_dbg_done", dbg_done, 0);
    exp = exp_q.pop_front();
    check("sim_t1_cpu_rdata", cpu_rdata, exp);
    step();
    cpu_cmd = 2'b00;
    @(negedge clk);
    check("sim_t2_read", ram_read, 1);
    check("sim_t2_addr", ram_addr, 9'h010);
    @(negedge clk);
    check("sim_t3_dbg_done", dbg_done, 1);
    check("sim_t3_cpu_done", cpu_done, 0);
    exp = exp_q.pop_front();
    check("sim_t3_dbg_rdata", dbg_rdata, exp);
    step();
    dbg_req = 1'b0;
    step();

    // Starvation: both held; expect C C C C D C C C C D.
    cpu_cmd = 2'b01; cpu_addr = 9'h0A0;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 9'h0B0;
    pat = '0; k = 0;
    for (int c = 0; c < 30 && k < 10; c++) begin
      @(negedge clk);
      if (ram_read) begin
        pat[k] = (ram_addr == 9'h0B0);
        k++;
      end
    end
    check("starve_grants", k, 10);
    check("starve_pattern", {22'd0, pat}, 32'b1000010000);
    step();
    cpu_cmd = 2'b00; dbg_req = 1'b0;
    step();
    step();

    // Reset during XFER of a CPU read.
    cpu_cmd = 2'b01; cpu_addr = 9'h005;
    @(negedge clk);
    check("rx_issue_read", ram_read, 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rx_no_done", cpu_done, 0);
    check("rx_no_rdata", cpu_rdata, 0);
    step();
    reset = 1'b0; cpu_cmd = 2'b00;
    @(negedge clk);
    check("rx_after_read", ram_read, 0);
    check("rx_after_done", cpu_done, 0);
    step();
    do_op(1'b0, 1'b1, 9'h007, 16'h0F0F);

    // Debug request withdrawn during a CPU XFER.
    cpu_cmd = 2'b10; cpu_addr = 9'h020; cpu_wdata = 16'h2020; model[9'h020] = 16'h2020;
    @(negedge clk);
    check("wd_cpu_write", ram_write, 1);
    step();
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 9'h0C0;
    @(negedge clk);
    check("wd_cpu_done", cpu_done, 1);
    check("wd_dbg_done_xfer", dbg_done, 0);
    step();
    dbg_req = 1'b0; cpu_cmd = 2'b00;
    strobes = 0; dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ram_read || ram_write) strobes++;
      if (dbg_done) dones++;
    end
    check("wd_no_strobe", strobes, 0);
    check("wd_no_dbg_done", dones, 0);
    step();
    do_op(1'b1, 1'b0, 9'h020, '0);

    // Random sequential traffic over a small address window.
    for (int i = 0; i < 16; i++)
      do_op(1'(i % 2), 1'b1, 9'(9'h100 + i), 16'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 30; i++)
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            9'(9'h100 + $urandom_range(0, 15)), 16'($urandom_range(0, 16'hFFFF)));

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, memory address width in bits.
REQ-002 Parameter DW, default 16, memory data width in bits.
REQ-003 Parameter BURST, default 4, maximum consecutive CPU grants while debug is pending (range 1-15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_cmd  input  2  CPU request: 00 none, 01 read, 10 write, 11 treated as none.
REQ-007 cpu_addr  input  AW  CPU address.
REQ-008 cpu_wdata  input  DW  CPU write data.
REQ-009 cpu_done  output  1  CPU access completes this cycle.
REQ-010 cpu_stall  output  1  CPU request pending and not completing this cycle.
REQ-011 cpu_rdata  output  DW  CPU read data, valid when cpu_done is high for a read.
REQ-012 dbg_req  input  1  debug/loader request valid.
REQ-013 dbg_write  input  1  debug access type: 1 write, 0 read.
REQ-014 dbg_addr  input  AW  debug address.
REQ-015 dbg_wdata  input  DW  debug write data.
REQ-016 dbg_done  output  1  debug access completes this cycle.
REQ-017 dbg_rdata  output  DW  debug read data, valid when dbg_done is high for a read.
REQ-018 ram_addr  output  AW  RAM address.
REQ-019 ram_read  output  1  RAM read strobe; RAM returns data on ram_rdata one cycle later.
REQ-020 ram_write  output  1  RAM write strobe; data is written at the clock edge.
REQ-021 ram_wdata  output  DW  RAM write data.
REQ-022 ram_rdata  input  DW  RAM read data, one-cycle synchronous latency.

Function
REQ-023 The FSM SHALL have two states: IDLE and XFER; the current owner (CPU or DBG) and the access type SHALL be held in registers.
REQ-024 In IDLE with at least one request pending, the arbiter SHALL pick a winner and drive ram_addr, ram_read/ram_write and ram_wdata from it in the same cycle (ISSUE), then move to XFER.
REQ-025 In IDLE with no request pending, the arbiter SHALL hold ram_read=0, ram_write=0 and stay in IDLE.
REQ-026 In XFER, the arbiter SHALL:
  - drive ram_read=0 and ram_write=0;
  - pulse the owner's done output for exactly one cycle;
  - route ram_rdata to the owner's rdata output;
  - return to IDLE.
  Each access is therefore 2 cycles, with at most 1 access per 2 cycles.
REQ-027 Priority SHALL go to the CPU, except when run_cnt equals BURST and dbg_req is high, in which case debug wins.
REQ-028 run_cnt is a 4-bit register and SHALL be updated as follows:
  - +1 on every CPU grant while dbg_req is high;
  - cleared on every debug grant;
  - cleared in any cycle in which dbg_req is low.
REQ-029 Requesters SHALL hold the command, address and write data stable from assertion through their done cycle inclusive; the arbiter SHALL sample them only in the ISSUE cycle.
REQ-030 A requester whose request is still asserted in the cycle after its done pulse SHALL be treated as a new request.
REQ-031 cpu_stall SHALL equal (cpu_cmd is 01 or 10) AND NOT cpu_done, combinationally.
REQ-032 The non-owner's done output SHALL be 0 at all times, and its rdata output SHALL be 0.
REQ-033 A request withdrawn before being granted SHALL be dropped without any RAM strobe.
REQ-034 Each done output SHALL pulse exactly once per granted access, with no spurious pulses.

Reset
REQ-035 While reset is high at a clock edge, the arbiter SHALL:
  - set the state to IDLE, the owner to CPU and run_cnt to 0;
  - clear all other registers.
REQ-036 During and immediately after reset, the following outputs SHALL be 0:
  - ram_read and ram_write;
  - cpu_done and dbg_done;
  - cpu_rdata and dbg_rdata.
  The only exception is cpu_stall, which follows REQ-031.
REQ-037 A reset asserted during XFER SHALL abort the access, suppress the done pulse and return the arbiter to IDLE at the next edge; a write already strobed in ISSUE is not undone.

Verification
REQ-038 CPU write: cpu_cmd=10, addr=0x005, wdata=0xABCD -> ram_write=1 with addr 0x005 in cycle T; cpu_done=1 at T+1; a later read of 0x005 returns 0xABCD.
REQ-039 Simultaneous requests: cpu_cmd=01 and dbg_req=1 in the same cycle with run_cnt=0 -> the CPU is granted first; the debug access is granted in the next ISSUE cycle (T+2), and dbg_done=1 at T+3.
REQ-040 Starvation (BURST=4): CPU requests back-to-back with dbg_req held high -> 4 CPU grants, then the debug grant on the 5th ISSUE cycle; run_cnt is back to 0 after the debug grant.
REQ-041 Debug read: 0x1234 preloaded at 0x010, debug read of 0x010 -> dbg_done=1 with dbg_rdata=0x1234; cpu_done and cpu_rdata stay 0.
REQ-042 Reset in XFER: assert reset in the XFER cycle of a CPU read -> no cpu_done pulse; state is IDLE; ram_read=0 the following cycle.
REQ-043 Withdrawal: dbg_req pulses for 1 cycle during a CPU XFER -> no debug RAM strobe and no dbg_done pulse.
